// File: rtl/uart_rx_buffered_if.sv
// Read-side bus between the UART RX buffer and the MMIO UART peripheral.
interface uart_rx_buffered_if #(
  parameter int unsigned BUF_DEPTH_LOG2 = 4
);
  logic [7:0]              uart_rx_data;
  logic                    uart_rx_empty;
  logic                    uart_rx_rd_en;
  logic                    rx_overflow;
  logic                    rx_overflow_clr;
  logic                    rx_frame_err;
  logic [BUF_DEPTH_LOG2:0] rx_count;

  modport master (
    output uart_rx_data, uart_rx_empty, rx_overflow, rx_frame_err, rx_count,
    input  uart_rx_rd_en, rx_overflow_clr
  );

  modport slave (
    input  uart_rx_data, uart_rx_empty, rx_overflow, rx_frame_err, rx_count,
    output uart_rx_rd_en, rx_overflow_clr
  );
endinterface

// File: rtl/uart_rx_buffered.sv
// Oversampling 8N1 UART receiver feeding a first-word-fall-through circular
// byte buffer, with sticky overflow and one-cycle framing-error reporting.
module uart_rx_buffered #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned BUF_DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uart_rx,
  uart_rx_buffered_if.master     bus
);

  localparam int unsigned DEPTH = 1 << BUF_DEPTH_LOG2;
  localparam int unsigned PW    = BUF_DEPTH_LOG2;
  localparam int unsigned CW    = BUF_DEPTH_LOG2 + 1;
  localparam int unsigned TW    = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] HALF_LOAD  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [TW-1:0]   tmr_q;
  logic            tmr_zero;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            armed_q;

  logic            load_half_c, load_full_c, shift_c, stop_done_c;
  logic            byte_wr_c, frame_err_c;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      data_q, head_d;
  logic            empty_q, ovf_q, ferr_q;
  logic            rd_c, full_c, wr_c, drop_c;

  assign rx_s     = sync_q[1];
  assign tmr_zero = (tmr_q == '0);

  // Two-flop synchroniser; idles high out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (armed_q && !rx_s) state_d = START;
      START:   if (tmr_zero) state_d = rx_s ? IDLE : DATA;
      DATA:    if (tmr_zero && bit_idx_q == 3'd7) state_d = STOP;
      STOP:    if (tmr_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_half_c = 1'b0;
    load_full_c = 1'b0;
    shift_c     = 1'b0;
    stop_done_c = 1'b0;
    byte_wr_c   = 1'b0;
    frame_err_c = 1'b0;
    unique case (state_q)
      IDLE:  load_half_c = armed_q && !rx_s;
      START: load_full_c = tmr_zero && !rx_s;
      DATA: begin
        shift_c     = tmr_zero;
        load_full_c = tmr_zero;
      end
      STOP: begin
        stop_done_c = tmr_zero;
        byte_wr_c   = tmr_zero && rx_s;
        frame_err_c = tmr_zero && !rx_s;
      end
      default: ;
    endcase
  end

  // Bit timer, LSB-first shifter and break-line arming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      if (load_half_c)      tmr_q <= HALF_LOAD;
      else if (load_full_c) tmr_q <= FULL_LOAD;
      else if (!tmr_zero)   tmr_q <= tmr_q - TW'(1);

      if (load_half_c)  bit_idx_q <= '0;
      else if (shift_c) bit_idx_q <= bit_idx_q + 3'd1;

      if (shift_c) shift_q <= {rx_s, shift_q[7:1]};

      if (stop_done_c)                   armed_q <= 1'b0;
      else if (state_q == IDLE && rx_s)  armed_q <= 1'b1;
    end
  end

  assign rd_c       = bus.uart_rx_rd_en && !empty_q;
  assign full_c     = (count_q == FULL_COUNT);
  assign wr_c       = byte_wr_c && (!full_c || rd_c);
  assign drop_c     = byte_wr_c && full_c && !rd_c;
  assign rd_ptr_nxt = rd_ptr_q + PW'(1);
  assign count_d    = count_q + CW'(wr_c) - CW'(rd_c);

  // Next head byte: registered so the output needs no read latency after a pop
  always_comb begin
    head_d = data_q;
    if (rd_c) begin
      if (count_q > CW'(1)) head_d = mem[rd_ptr_nxt];
      else if (wr_c)        head_d = shift_q;
    end else if (empty_q && wr_c) begin
      head_d = shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (wr_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_c) rd_ptr_q <= rd_ptr_nxt;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      data_q  <= head_d;
      ferr_q  <= frame_err_c;
      if (drop_c)                   ovf_q <= 1'b1;
      else if (bus.rx_overflow_clr) ovf_q <= 1'b0;
    end
  end

  assign bus.uart_rx_data  = data_q;
  assign bus.uart_rx_empty = empty_q;
  assign bus.rx_overflow   = ovf_q;
  assign bus.rx_frame_err  = ferr_q;
  assign bus.rx_count      = count_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: frames are driven bit-serially, expected
// bytes are queued at send time and checked by a monitor on every pop.
module tb_uart_rx_buffered;
  localparam int unsigned CPB  = 8;
  localparam int unsigned LOG2 = 4;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic uart_rx = 1'b1;

  uart_rx_buffered_if #(.BUF_DEPTH_LOG2(LOG2)) bus ();

  uart_rx_buffered #(
    .CLKS_PER_BIT   (CPB),
    .BUF_DEPTH_LOG2 (LOG2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] expq [$];
  int vectors     = 0;
  int miscompares = 0;
  int ferr_cycles = 0;
  int lat         = 0;
  int ferr0       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit kept);
    if (kept) expq.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic pop();
    bus.uart_rx_rd_en = 1'b1;
    @(negedge clk);
    bus.uart_rx_rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.rx_frame_err === 1'b1) ferr_cycles++;
      if (bus.uart_rx_rd_en === 1'b1 && bus.uart_rx_empty === 1'b0) begin
        if (expq.size() == 0) begin
          check("pop_unexpected", 32'(bus.uart_rx_data), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(bus.uart_rx_data), 32'(expq.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.uart_rx_rd_en   = 1'b0;
    bus.rx_overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_empty", 32'(bus.uart_rx_empty), 32'd1);
    check("rst_data",  32'(bus.uart_rx_data),  32'h00);
    check("rst_ovf",   32'(bus.rx_overflow),   32'd0);
    check("rst_ferr",  32'(bus.rx_frame_err),  32'd0);
    check("rst_count", 32'(bus.rx_count),      32'd0);
    idle(4);

    // Single byte with exact write latency from start-bit edge
    fork
      send_byte(8'h55, 1'b1);
      begin
        lat = 0;
        while (bus.uart_rx_empty && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("single_latency", 32'(lat), 32'd79);
    check("single_data",  32'(bus.uart_rx_data), 32'h55);
    check("single_count", 32'(bus.rx_count), 32'd1);
    pop();
    check("single_empty_after", 32'(bus.uart_rx_empty), 32'd1);
    check("single_count_after", 32'(bus.rx_count), 32'd0);

    // Burst of 17 into a 16-deep buffer
    for (int b = 0; b < 17; b++) send_byte(8'(b), b < 16);
    idle(4);
    check("burst_count", 32'(bus.rx_count), 32'd16);
    check("burst_ovf",   32'(bus.rx_overflow), 32'd1);
    check("burst_head",  32'(bus.uart_rx_data), 32'h00);
    for (int i = 0; i < 16; i++) pop();
    check("burst_drained_count", 32'(bus.rx_count), 32'd0);
    check("burst_drained_empty", 32'(bus.uart_rx_empty), 32'd1);
    check("burst_ovf_sticky", 32'(bus.rx_overflow), 32'd1);
    bus.rx_overflow_clr = 1'b1;
    @(negedge clk);
    bus.rx_overflow_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(bus.rx_overflow), 32'd0);

    // Pop in the same cycle a byte lands in a full buffer
    for (int b = 8'h20; b < 8'h30; b++) send_byte(8'(b), 1'b1);
    check("full_count", 32'(bus.rx_count), 32'd16);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (78) @(negedge clk);
        bus.uart_rx_rd_en = 1'b1;
        @(negedge clk);
        bus.uart_rx_rd_en = 1'b0;
      end
    join
    idle(2);
    check("simul_count", 32'(bus.rx_count), 32'd16);
    check("simul_ovf",   32'(bus.rx_overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop();
    check("simul_empty", 32'(bus.uart_rx_empty), 32'd1);

    // Short low glitch on an idle line
    ferr0 = ferr_cycles;
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    check("glitch_count", 32'(bus.rx_count), 32'd0);
    check("glitch_empty", 32'(bus.uart_rx_empty), 32'd1);
    check("glitch_ferr",  32'(ferr_cycles - ferr0), 32'd0);
    send_byte(8'h3C, 1'b1);
    idle(2);
    check("glitch_next_count", 32'(bus.rx_count), 32'd1);
    pop();

    // Stop bit low followed by a held break
    ferr0 = ferr_cycles;
    send_frame(8'h81, 1'b0);
    uart_rx = 1'b0;
    repeat (3 * 10 * CPB) @(negedge clk);
    idle(20);
    check("break_ferr_pulses", 32'(ferr_cycles - ferr0), 32'd1);
    check("break_count", 32'(bus.rx_count), 32'd0);
    send_byte(8'h42, 1'b1);
    idle(2);
    check("break_next_count", 32'(bus.rx_count), 32'd1);
    pop();

    // Async reset during data bit 4 with two bytes buffered
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("prereset_count", 32'(bus.rx_count), 32'd2);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (44) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_empty", 32'(bus.uart_rx_empty), 32'd1);
        check("midreset_count", 32'(bus.rx_count), 32'd0);
        check("midreset_data",  32'(bus.uart_rx_data), 32'h00);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    idle(4);
    check("postreset_count0", 32'(bus.rx_count), 32'd0);
    send_byte(8'h99, 1'b1);
    idle(2);
    check("postreset_count", 32'(bus.rx_count), 32'd1);
    check("postreset_data",  32'(bus.uart_rx_data), 32'h99);
    pop();
    idle(2);
    check("final_empty", 32'(bus.uart_rx_empty), 32'd1);
    check("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
